// File: rtl/breathing_pkg.sv
// rtl/breathing_pkg.sv - shared widths, defaults and FSM encoding for the switch debouncer
//
// Contents:
//   SW_W                 width of the slide-switch vector
//   DEBOUNCE_CYCLES_DEF  default qualification length in clock cycles
//   IDLE / WAIT          debouncer state encoding
//   cnt_width()          counter width able to hold 0..cycles-1

package breathing_pkg;

    localparam int SW_W                = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    // The counter only ever has to reach cycles-1, so $clog2(cycles) bits are
    // enough; clamp to one bit so tiny settings still give a legal vector.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a vector of asynchronous levels
//
// Parameters:
//   WIDTH      number of bits synchronized
//   RESET_VAL  value both stages take while rst is low
// Ports:
//   clk  in   sampling clock
//   rst  in   asynchronous active-low reset
//   d    in   asynchronous input levels
//   q    out  synchronized levels (second stage)

module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - debounces a 4-bit slide-switch vector as one unit
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive identical synchronized samples needed to accept a value
//   RESET_VAL        value presented on sw_db during and after reset
// Ports:
//   clk     in   system clock, rising-edge
//   rst     in   asynchronous active-low reset
//   sw      in   raw asynchronous switch levels
//   sw_db   out  debounced switch value
//   sw_chg  out  one-cycle strobe after sw_db takes a new value
//   busy    out  high while a candidate value is being qualified
// Build option:
//   SW_DEBOUNCE_CHG_EN  when defined sw_chg is generated; otherwise it is tied low

module sw_debounce
    import breathing_pkg::*;
#(
    parameter int              DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [SW_W-1:0] RESET_VAL       = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] sw_db,
    output logic            sw_chg,
    output logic            busy
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SW_W-1:0]  s2;
    logic [0:0]       state;
    logic [SW_W-1:0]  cand;
    logic [CNT_W-1:0] cnt;

    sync_2ff #(
        .WIDTH     (SW_W),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (s2)
    );

    // cnt counts samples of cand already seen, so the sample arriving with
    // cnt == CNT_LAST is the DEBOUNCE_CYCLES-th and cnt never passes CNT_LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cand  <= RESET_VAL;
            cnt   <= '0;
            sw_db <= RESET_VAL;
        end else begin
            case (state)
                IDLE: begin
                    if (s2 != sw_db) begin
                        cand  <= s2;
                        cnt   <= CNT_ONE;
                        state <= WAIT;
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    if (s2 == cand) begin
                        if (cnt == CNT_LAST) begin
                            sw_db <= cand;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else if (s2 == sw_db) begin
                        // Bounced back to the accepted value: drop the candidate.
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        // A different bit pattern restarts qualification.
                        cand <= s2;
                        cnt  <= CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == WAIT);

`ifdef SW_DEBOUNCE_CHG_EN
    logic accept;
    assign accept = (state == WAIT) && (s2 == cand) && (cnt == CNT_LAST);

    // Registered alongside sw_db so the strobe lines up with the new value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_chg <= 1'b0;
        end else begin
            sw_chg <= accept;
        end
    end
`else
    assign sw_chg = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - self-checking bench for sw_debounce with DEBOUNCE_CYCLES = 4

module tb_sw_debounce;

    localparam int D = 4;
`ifdef SW_DEBOUNCE_CHG_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw  = 4'b0000;
    logic [3:0] sw_db;
    logic       sw_chg;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    int chg_cnt = 0;

    sw_debounce #(
        .DEBOUNCE_CYCLES (D),
        .RESET_VAL       (4'b0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .sw_db  (sw_db),
        .sw_chg (sw_chg),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Model: the debounced value is the synchronized stream (sw delayed by two
    // samples) once the same value has been seen D times in a row and differs
    // from the current output. Busy means the newest sample disagrees with it.
    logic [3:0] m_s1 = 4'b0000, m_s2 = 4'b0000, m_db = 4'b0000, m_run_val = 4'b0000;
    int         m_run_len = 0;
    logic       m_busy = 1'b0, m_chg = 1'b0;

    initial begin
        logic [3:0] x;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_s1 = 4'b0000; m_s2 = 4'b0000; m_db = 4'b0000;
                m_run_val = 4'b0000; m_run_len = 0;
                m_busy = 1'b0; m_chg = 1'b0;
            end else begin
                x    = m_s2;
                m_s2 = m_s1;
                m_s1 = sw;
                if (x == m_run_val) m_run_len++;
                else begin
                    m_run_val = x;
                    m_run_len = 1;
                end
                m_chg = 1'b0;
                if (x != m_db && m_run_len >= D) begin
                    m_db  = x;
                    m_chg = CHG_EN;
                end
                m_busy = (x != m_db);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_sw_db", sw_db, m_db);
            chk("model_busy", {3'b0, busy}, {3'b0, m_busy});
            chk("model_sw_chg", {3'b0, sw_chg}, {3'b0, m_chg});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (sw_chg === 1'b1) chg_cnt++;
    endtask

    initial begin
        // Reset release with sw already at a new value.
        sw = 4'b0110;
        repeat (3) tick();
        chk("rst_sw_db", sw_db, 4'b0000);
        chk("rst_busy", {3'b0, busy}, 4'b0000);
        rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("rel_sw_db", sw_db, (k >= 5) ? 4'b0110 : 4'b0000);
            chk("rel_busy", {3'b0, busy}, {3'b0, (k >= 2 && k <= 4)});
            chk("rel_sw_chg", {3'b0, sw_chg}, {3'b0, (k == 5) && CHG_EN});
        end

        // Three-cycle glitch to 0100 is rejected.
        sw = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 2) sw = 4'b0110;
            chk("glitch_sw_db", sw_db, 4'b0110);
            chk("glitch_busy", {3'b0, busy}, {3'b0, (k >= 2 && k <= 4)});
            chk("glitch_sw_chg", {3'b0, sw_chg}, 4'b0000);
        end

        // Bit0 chatter, then a stable 0111.
        chg_cnt = 0;
        for (int t = 0; t < 4; t++) begin
            sw = t[0] ? 4'b0110 : 4'b0111;
            repeat (2) tick();
        end
        sw = 4'b0111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("chatter_sw_db", sw_db, (k >= 5) ? 4'b0111 : 4'b0110);
        end
        chk("chatter_chg_count", 4'(chg_cnt), CHG_EN ? 4'd1 : 4'd0);

        // Reset while qualifying candidate 0111.
        sw = 4'b0110;
        repeat (8) tick();
        chk("pre_sw_db", sw_db, 4'b0110);
        sw = 4'b0111;
        repeat (3) tick();
        chk("mid_busy", {3'b0, busy}, 4'b0001);
        chk("mid_sw_db", sw_db, 4'b0110);
        #1 rst = 1'b0;
        #1;
        chk("async_sw_db", sw_db, 4'b0000);
        chk("async_busy", {3'b0, busy}, 4'b0000);
        chk("async_sw_chg", {3'b0, sw_chg}, 4'b0000);
        repeat (2) tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rerel_sw_db", sw_db, (k == 5) ? 4'b0111 : 4'b0000);
            chk("rerel_busy", {3'b0, busy}, {3'b0, (k >= 2 && k <= 4)});
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
